trsq_sequencer: RTL
===================

Name: trsq_sequencer

Overview:
- Parametrised program sequencer for the next-generation TRSQ core; replaces the fixed PC/single-slot interrupt logic of the 8-bit core.
- Owns the PC, a multi-entry return stack shared by CALL and interrupts, halt/wake, and a prioritised vectored interrupt controller with a global enable.
- Sits between the instruction decoder (control strobes in) and the program ROM (address out).
- Tells the datapath when to discard the fetched instruction and when to save or restore W/STATUS.

Parameters:
- PC_W, 13, program-counter and ROM-address width.
- STACK_DEPTH, 4, return-stack entries (>=1).
- N_IRQ, 4, interrupt request lines (1..8).
- VECTOR_BASE, 4, address of the vector for irq 0.
- VECTOR_STRIDE, 2, address distance between consecutive vectors.

Ports:
- clk_ip  in  1  clock; all state updates on the rising edge.
- reset_ip  in  1  synchronous reset, active-high.
- jump_ip  in  1  decoded JMP.
- call_ip  in  1  decoded CALL.
- return_ip  in  1  decoded RET.
- reti_ip  in  1  decoded RETI.
- halt_ip  in  1  decoded HALT.
- skip_ip  in  1  skip condition already resolved against the flags.
- target_ip  in  PC_W  jump/call target.
- gie_set_ip  in  1  set global interrupt enable.
- gie_clr_ip  in  1  clear global interrupt enable.
- irq_ip  in  N_IRQ  level-sensitive requests.
- irq_en_ip  in  N_IRQ  per-line mask.
- clr_err_ip  in  1  clear the sticky stack error flags.
- pc_op  out  PC_W  program ROM address.
- squash_op  out  1  combinational; the datapath must not commit this cycle.
- save_op  out  1  one-cycle pulse: push W/STATUS (interrupt entry).
- restore_op  out  1  one-cycle pulse: pop W/STATUS (RETI).
- irq_ack_op  out  N_IRQ  one-hot one-cycle acknowledge.
- gie_op  out  1  global interrupt enable.
- in_isr_op  out  1  interrupt nesting count is non-zero.
- halted_op  out  1  sequencer is in HALT.
- stack_ovf_op  out  1  sticky: push attempted while full.
- stack_unf_op  out  1  sticky: pop attempted while empty.

Behaviour:
- Reset (synchronous, active-high, overrides everything):
  - pc=0, state RUN, gie=0, stack pointer=0, nest count=0.
  - Both sticky flags 0; all pulses 0; squash_op=0.
- pending = irq_ip & irq_en_ip. The selected source is the lowest set index.
- States: RUN, HALT.
- RUN, evaluated in priority order each cycle:
  1. gie & |pending (interrupt entry):
     - squash_op=1; the fetched instruction is discarded, including any strobe in the same cycle.
     - Push pc_op so the discarded instruction re-executes after RETI.
     - pc <= VECTOR_BASE + idx*VECTOR_STRIDE, truncated to PC_W.
     - gie<=0; save_op=1; irq_ack_op[idx]=1; nest count +1.
  2. halt_ip: pc<=pc+1, state HALT.
  3. call_ip: push pc+1, pc<=target_ip.
  4. jump_ip: pc<=target_ip.
  5. return_ip: pop into pc.
  6. reti_ip: pop into pc; gie<=1; restore_op=1; nest count -1, saturating at 0.
  7. skip_ip: pc<=pc+2.
  8. Otherwise: pc<=pc+1.
- All PC arithmetic wraps modulo 2^PC_W.
- HALT:
  - pc holds; squash_op=1.
  - Exit when |pending:
    - gie=1: perform interrupt entry from HALT; pushed address is the held pc.
    - gie=0: return to RUN; execution resumes at the held pc.
  - Wake latency: one cycle after pending is seen.
- gie_set_ip and gie_clr_ip take effect on the next edge.
  - Both asserted: clear wins.
  - Interrupt entry in the same cycle overrides both (gie<=0).
- Stack:
  - Push when full: entry dropped, stack_ovf_op<=1, PC still redirects.
  - Pop when empty: pc<=pc+1, stack_unf_op<=1.
  - Sticky flags clear only on reset or clr_err_ip.
  - Simultaneous set and clr_err_ip: set wins.
- Nesting: RETI sets gie=1, so a pending request is taken on the cycle after RETI. Back-to-back service is legal.
- Decoder strobes are mutually exclusive. If several are asserted, the priority order above decides.

Decomposition:
- Shared package trsq_pkg holds:
  - state enum (RUN, HALT);
  - next-PC select enum (INC, SKIP, TARGET, POP, VECTOR, HOLD);
  - helper function for the stack-pointer width, clog2(STACK_DEPTH+1).
- Sub-module trsq_call_stack: parametrised LIFO of PC_W x STACK_DEPTH.
  - push/pop inputs, top output, full/empty outputs.
  - Push and pop in the same cycle is illegal and is never generated.

Test Plan:
- Reset, then 5 plain cycles -> pc_op 0,1,2,3,4; gie_op=0; both sticky flags 0.
- At pc=0x1FFF, no strobe -> pc wraps to 0x0000. At pc=0x1FFE with skip_ip -> pc=0x0000.
- call_ip target 0x100 at pc=0x10, then return_ip -> pc 0x100 then 0x11. Five nested calls with STACK_DEPTH=4 -> stack_ovf_op=1 on the fifth call. Five returns -> fifth gives pc+1 and stack_unf_op=1.
- gie=1, irq_ip=4'b1010, en=4'b1111, jump_ip asserted at pc=0x20:
  - jump squashed; pc=4+1*2=6; irq_ack_op=4'b0010; save_op pulse; gie_op=0.
  - A later reti_ip -> pc=0x20, gie_op=1, restore_op pulse.
- halt_ip at pc=0x30, gie=0 -> pc holds at 0x31, halted_op=1. irq_ip[0] with en[0] -> RUN next cycle at 0x31, no ack.
- gie=1 in HALT at 0x31, irq_ip[2] with en[2] -> pc=8, pushed 0x31, irq_ack_op=4'b0100. reset_ip asserted mid-ISR -> pc=0, in_isr_op=0, stack empty.

Source files
------------

// File: rtl/trsq_pkg.sv
// Shared types for the TRSQ program sequencer: FSM states, next-PC selects
// and the stack-pointer width helper.
// Latency: n/a (declarations only). Backpressure: n/a.
package trsq_pkg;

  typedef enum logic {
    RUN,
    HALT
  } seq_state_t;

  typedef enum logic [2:0] {
    INC,
    SKIP,
    TARGET,
    POP,
    VECTOR,
    HOLD
  } pc_sel_t;

  // Width of the interrupt nesting counter (saturates at all-ones).
  localparam int NEST_W = 8;

  // Pointer must represent 0..depth inclusive so "full" is distinguishable.
  function automatic int sp_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/trsq_sequencer_if.sv
// Decoder/ROM-side signal bundle of the TRSQ sequencer.
// Latency: n/a (wires only). Backpressure: none; strobes are single-cycle.
// Ports: master = decoder/datapath side, slave = sequencer side.
interface trsq_sequencer_if #(
  parameter int PC_W  = 13,
  parameter int N_IRQ = 4
);
  logic             jump_ip;
  logic             call_ip;
  logic             return_ip;
  logic             reti_ip;
  logic             halt_ip;
  logic             skip_ip;
  logic [PC_W-1:0]  target_ip;
  logic             gie_set_ip;
  logic             gie_clr_ip;
  logic [N_IRQ-1:0] irq_ip;
  logic [N_IRQ-1:0] irq_en_ip;
  logic             clr_err_ip;

  logic [PC_W-1:0]  pc_op;
  logic             squash_op;
  logic             save_op;
  logic             restore_op;
  logic [N_IRQ-1:0] irq_ack_op;
  logic             gie_op;
  logic             in_isr_op;
  logic             halted_op;
  logic             stack_ovf_op;
  logic             stack_unf_op;

  modport master (
    output jump_ip, call_ip, return_ip, reti_ip, halt_ip, skip_ip, target_ip,
           gie_set_ip, gie_clr_ip, irq_ip, irq_en_ip, clr_err_ip,
    input  pc_op, squash_op, save_op, restore_op, irq_ack_op, gie_op,
           in_isr_op, halted_op, stack_ovf_op, stack_unf_op
  );

  modport slave (
    input  jump_ip, call_ip, return_ip, reti_ip, halt_ip, skip_ip, target_ip,
           gie_set_ip, gie_clr_ip, irq_ip, irq_en_ip, clr_err_ip,
    output pc_op, squash_op, save_op, restore_op, irq_ack_op, gie_op,
           in_isr_op, halted_op, stack_ovf_op, stack_unf_op
  );
endinterface

// File: rtl/trsq_call_stack.sv
// Return-address LIFO shared by CALL and interrupt entry.
// Latency: push/pop visible on top/full/empty one cycle after the edge.
// Backpressure: none; push when full is dropped, pop when empty is ignored.
// Ports: clk_ip/reset_ip, push/pop strobes, push_dat in, top/full/empty out.
module trsq_call_stack
  import trsq_pkg::*;
#(
  parameter int PC_W        = 13,
  parameter int STACK_DEPTH = 4
) (
  input  logic            clk_ip,
  input  logic            reset_ip,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_dat,
  output logic [PC_W-1:0] top,
  output logic            full,
  output logic            empty
);
  localparam int SP_W = sp_width(STACK_DEPTH);

  logic [SP_W-1:0] sp;
  // Entry 0 is always the top of stack; pushes shift down, pops shift up.
  logic [PC_W-1:0] mem [STACK_DEPTH];

  assign full  = (sp == SP_W'(STACK_DEPTH));
  assign empty = (sp == '0);
  assign top   = mem[0];

  always_ff @(posedge clk_ip) begin
    if (reset_ip) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + 1'b1;
    end else if (pop && !empty) begin
      sp <= sp - 1'b1;
    end
  end

  always_ff @(posedge clk_ip) begin
    if (push && !full) begin
      mem[0] <= push_dat;
      for (int i = 1; i < STACK_DEPTH; i++) mem[i] <= mem[i-1];
    end else if (pop && !empty) begin
      for (int i = 0; i < STACK_DEPTH - 1; i++) mem[i] <= mem[i+1];
    end
  end
endmodule

// File: rtl/trsq_sequencer.sv
// Program sequencer: PC, return stack, halt/wake, vectored prioritised IRQs.
// Latency: PC updates on every edge; squash/save/restore/ack are combinational.
// Backpressure: none; HALT holds the PC and squashes until a pending request.
// Ports: clk_ip, reset_ip (sync, active-high), seq = decoder/ROM bundle.
module trsq_sequencer
  import trsq_pkg::*;
#(
  parameter int PC_W          = 13,
  parameter int STACK_DEPTH   = 4,
  parameter int N_IRQ         = 4,
  parameter int VECTOR_BASE   = 4,
  parameter int VECTOR_STRIDE = 2
) (
  input  logic             clk_ip,
  input  logic             reset_ip,
  trsq_sequencer_if.slave  seq
);
  seq_state_t        state, state_nxt;
  pc_sel_t           pc_sel;
  logic [PC_W-1:0]   pc, pc_nxt, push_dat, top, vec_pc;
  logic              gie, gie_nxt;
  logic [NEST_W-1:0] nest, nest_nxt;
  logic              ovf, unf, ovf_set, unf_set;
  logic              push, pop, full, empty;
  logic              take_irq, reti_exec, squash;
  logic [N_IRQ-1:0]  pending;
  logic [2:0]        irq_idx;

  assign pending = seq.irq_ip & seq.irq_en_ip;

  // Lowest set index wins: scan downward so the last hit is the lowest.
  always_comb begin
    irq_idx = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (pending[i]) irq_idx = 3'(i);
    end
  end

  assign vec_pc = PC_W'(VECTOR_BASE) + PC_W'(irq_idx) * PC_W'(VECTOR_STRIDE);

  always_comb begin
    state_nxt = state;
    pc_sel    = INC;
    push      = 1'b0;
    pop       = 1'b0;
    push_dat  = pc + 1'b1;
    take_irq  = 1'b0;
    reti_exec = 1'b0;
    squash    = 1'b0;
    unf_set   = 1'b0;
    if (!reset_ip) begin
      unique case (state)
        RUN: begin
          if (gie && |pending) begin
            take_irq = 1'b1;
          end else if (seq.halt_ip) begin
            state_nxt = HALT;
          end else if (seq.call_ip) begin
            push   = 1'b1;
            pc_sel = TARGET;
          end else if (seq.jump_ip) begin
            pc_sel = TARGET;
          end else if (seq.return_ip || seq.reti_ip) begin
            reti_exec = !seq.return_ip;
            // Underflow falls through to pc+1 so execution keeps moving.
            if (empty) unf_set = 1'b1;
            else begin
              pop    = 1'b1;
              pc_sel = POP;
            end
          end else if (seq.skip_ip) begin
            pc_sel = SKIP;
          end
        end
        HALT: begin
          pc_sel = HOLD;
          squash = 1'b1;
          if (|pending) begin
            if (gie) take_irq = 1'b1;
            else     state_nxt = RUN;
          end
        end
      endcase
      // Entry pushes the current PC so the squashed instruction re-executes.
      if (take_irq) begin
        squash    = 1'b1;
        push      = 1'b1;
        push_dat  = pc;
        pc_sel    = VECTOR;
        state_nxt = RUN;
      end
    end
  end

  assign ovf_set = push && full;

  always_comb begin
    unique case (pc_sel)
      INC:     pc_nxt = pc + 1'b1;
      SKIP:    pc_nxt = pc + PC_W'(2);
      TARGET:  pc_nxt = seq.target_ip;
      POP:     pc_nxt = top;
      VECTOR:  pc_nxt = vec_pc;
      HOLD:    pc_nxt = pc;
      default: pc_nxt = pc;
    endcase
  end

  // GIE strobes are decoder outputs and are ignored while squashing.
  always_comb begin
    gie_nxt = gie;
    if (take_irq)                          gie_nxt = 1'b0;
    else if (state == RUN && !reset_ip) begin
      if (reti_exec)                       gie_nxt = 1'b1;
      else if (seq.gie_clr_ip)             gie_nxt = 1'b0;
      else if (seq.gie_set_ip)             gie_nxt = 1'b1;
    end
  end

  always_comb begin
    nest_nxt = nest;
    if (take_irq && nest != '1)            nest_nxt = nest + 1'b1;
    else if (reti_exec && nest != '0)      nest_nxt = nest - 1'b1;
  end

  always_ff @(posedge clk_ip) begin
    if (reset_ip) begin
      state <= RUN;
      pc    <= '0;
      gie   <= 1'b0;
      nest  <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      gie   <= gie_nxt;
      nest  <= nest_nxt;
      // A new error in the same cycle as the clear must survive.
      ovf   <= ovf_set | (ovf & !seq.clr_err_ip);
      unf   <= unf_set | (unf & !seq.clr_err_ip);
    end
  end

  trsq_call_stack #(
    .PC_W        (PC_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk_ip   (clk_ip),
    .reset_ip (reset_ip),
    .push     (push),
    .pop      (pop),
    .push_dat (push_dat),
    .top      (top),
    .full     (full),
    .empty    (empty)
  );

  always_comb begin
    for (int i = 0; i < N_IRQ; i++) seq.irq_ack_op[i] = take_irq && (irq_idx == 3'(i));
  end

  assign seq.pc_op        = pc;
  assign seq.squash_op    = squash;
  assign seq.save_op      = take_irq;
  assign seq.restore_op   = reti_exec;
  assign seq.gie_op       = gie;
  assign seq.in_isr_op    = |nest;
  assign seq.halted_op    = (state == HALT);
  assign seq.stack_ovf_op = ovf;
  assign seq.stack_unf_op = unf;
endmodule
